// File: rtl/ram_uart_dump.sv
// ram_uart_dump: walks the data RAM after end-of-run and sends each word as two UART 8N1 bytes, high byte first; `define DUMP_CHECKSUM_EN appends an XOR checksum byte
module ram_uart_dump #(
  parameter int CLK_DIV    = 868,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int WORD_COUNT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, DONE
`ifdef DUMP_CHECKSUM_EN
    , CKSUM
`endif
  } state_t;
  state_t state, next;
  logic rearm, lo, bit_end, frame_end, last, sending;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DW-1:0] div;
  logic [3:0] bitn;
  logic [9:0] frame;
  logic [7:0] lo_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0] cks;
  assign sending = state == SEND || state == CKSUM;
`else
  assign sending = state == SEND;
`endif
  assign bit_end   = div == DW'(CLK_DIV - 1);
  assign frame_end = bit_end && bitn == 4'd9;
  assign last      = idx == ADDR_WIDTH'(WORD_COUNT - 1);
  assign tx        = frame[0];
  assign busy      = state != IDLE && state != DONE;
  assign done      = state == DONE;
  assign ram_re    = state == FETCH;
  assign ram_addr  = state == IDLE ? '0 : idx;
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = start && rearm ? FETCH : IDLE;
      FETCH: next = LATCH;
      LATCH: next = SEND;
`ifdef DUMP_CHECKSUM_EN
      SEND:  next = frame_end && lo ? (last ? CKSUM : FETCH) : SEND;
      CKSUM: next = frame_end ? DONE : CKSUM;
`else
      SEND:  next = frame_end && lo ? (last ? DONE : FETCH) : SEND;
`endif
      DONE:  next = start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rearm   <= 1'b1;
      idx     <= '0;
      div     <= '0;
      bitn    <= '0;
      lo      <= 1'b0;
      frame   <= '1;
      lo_byte <= '0;
`ifdef DUMP_CHECKSUM_EN
      cks     <= '0;
`endif
    end else begin
      state <= next;
      if (state == IDLE && next == FETCH) begin
        idx   <= '0;
        rearm <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
        cks   <= '0;
`endif
      end
      if (state == DONE && !start)
        rearm <= 1'b1;
      if (state == LATCH) begin
        lo_byte <= ram_data[7:0];
        frame   <= {1'b1, ram_data[15:8], 1'b0};
        div     <= '0;
        bitn    <= '0;
        lo      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
        cks     <= cks ^ ram_data[15:8];
`endif
      end
      if (sending) begin
        div <= bit_end ? '0 : div + 1'b1;
        if (bit_end) begin
          frame <= {1'b1, frame[9:1]};
          bitn  <= bitn + 4'd1;
        end
        if (frame_end) begin
          bitn <= '0;
          if (state == SEND) begin
            if (!lo) begin
              frame <= {1'b1, lo_byte, 1'b0};
              lo    <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
              cks   <= cks ^ lo_byte;
`endif
            end else if (!last) begin
              idx <= idx + 1'b1;
            end
`ifdef DUMP_CHECKSUM_EN
            else begin
              frame <= {1'b1, cks, 1'b0};
            end
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ram_uart_dump.sv
// tb_ram_uart_dump: UART-decoding bench for ram_uart_dump against a word-list reference model
module tb_ram_uart_dump;
  logic clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic [15:0] rd0 = '0, rd1 = '0;
  logic [0:0] addr0;
  logic [5:0] addr1;
  logic re0, re1, tx0, tx1, busy0, busy1, done0, done1;
  logic [15:0] mem0 [2];
  logic [15:0] mem1 [64];
  int vectors = 0, miscompares = 0, cyc = 0;
  int t_busy [2], t_done [2];
  logic bq [2] = '{1'b0, 1'b0};
  logic dq [2] = '{1'b0, 1'b0};
  int rq0 [$], rq1 [$];
  logic [7:0] exp_q [$];

  ram_uart_dump #(.CLK_DIV(4), .ADDR_WIDTH(1), .WORD_COUNT(2)) u0 (
    .clk(clk), .reset(reset), .start(start0), .ram_data(rd0), .ram_addr(addr0),
    .ram_re(re0), .tx(tx0), .busy(busy0), .done(done0));
  ram_uart_dump #(.CLK_DIV(2)) u1 (
    .clk(clk), .reset(reset), .start(start1), .ram_data(rd1), .ram_addr(addr1),
    .ram_re(re1), .tx(tx1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re0) begin
      rd0 <= mem0[addr0];
      rq0.push_back(int'(addr0));
    end
    if (re1) begin
      rd1 <= mem1[addr1];
      rq1.push_back(int'(addr1));
    end
  end

  always @(negedge clk) begin
    if (busy0 && !bq[0]) t_busy[0] = cyc;
    if (busy1 && !bq[1]) t_busy[1] = cyc;
    if (done0 && !dq[0]) t_done[0] = cyc;
    if (done1 && !dq[1]) t_done[1] = cyc;
    bq[0] = busy0; bq[1] = busy1;
    dq[0] = done0; dq[1] = done1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  function automatic logic txw(input bit w);
    return w ? tx1 : tx0;
  endfunction

  function automatic logic donew(input bit w);
    return w ? done1 : done0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic decode(input bit w, input string tag, output logic [7:0] b, output logic stop);
    int n = 0;
    int div = w ? 2 : 4;
    while (txw(w) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start_bit"}, 32'(txw(w)), 32'd0);
    repeat (div / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = txw(w);
    end
    repeat (div) @(negedge clk);
    stop = txw(w);
  endtask

  task automatic check_dump(input bit w, input string tag, input bit drop_start);
    int words = w ? 64 : 2;
    int div = w ? 2 : 4;
    int n = 0;
    int lat;
    logic [7:0] x = '0, b;
    logic s;
    exp_q.delete();
    for (int i = 0; i < words; i++) begin
      logic [15:0] wd = w ? mem1[i] : mem0[i];
      exp_q.push_back(wd[15:8]);
      exp_q.push_back(wd[7:0]);
      x ^= wd[15:8] ^ wd[7:0];
    end
    lat = words * (2 + 20 * div);
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(x);
    lat += 10 * div;
`endif
    foreach (exp_q[i]) begin
      decode(w, $sformatf("%s byte%0d", tag, i), b, s);
      chk($sformatf("%s byte%0d", tag, i), 32'(b), 32'(exp_q[i]));
      chk($sformatf("%s stop%0d", tag, i), 32'(s), 32'd1);
      if (drop_start && i == 0) start0 = 1'b0;
    end
    while (donew(w) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " done"}, 32'(donew(w)), 32'd1);
    @(negedge clk);
    chk({tag, " done_latency"}, 32'(t_done[w] - t_busy[w]), 32'(lat));
  endtask

  initial begin
    int n;
    mem0[0] = 16'hA55A;
    mem0[1] = 16'h0102;
    for (int i = 0; i < 64; i++) mem1[i] = 16'(i);
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx0), 32'd1);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst ram_re", 32'(re0), 32'd0);
    chk("rst ram_addr", 32'(addr0), 32'd0);
    chk("rst tx1", 32'(tx1), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    check_dump(0, "d1", 0);
    chk("d1 reads", 32'(rq0.size()), 32'd2);
    chk("d1 addr0", 32'(rq0[0]), 32'd0);
    chk("d1 addr1", 32'(rq0[1]), 32'd1);
    repeat (30) @(negedge clk);
    chk("hold reads", 32'(rq0.size()), 32'd2);
    chk("hold done", 32'(done0), 32'd1);
    chk("hold busy", 32'(busy0), 32'd0);
    start0 = 1'b0;
    @(negedge clk);
    chk("drop done", 32'(done0), 32'd0);
    start0 = 1'b1;
    check_dump(0, "d2", 0);
    chk("d2 reads", 32'(rq0.size()), 32'd4);
    start0 = 1'b0;
    @(negedge clk);
    mem0[0] = 16'($urandom);
    mem0[1] = 16'($urandom);
    start0 = 1'b1;
    check_dump(0, "d3", 1);
    chk("d3 reads", 32'(rq0.size()), 32'd6);
    mem0[0] = 16'hA55A;
    mem0[1] = 16'h0102;
    start0 = 1'b1;
    n = 0;
    while (busy0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("d4 busy", 32'(busy0), 32'd1);
    repeat (46) @(negedge clk);
    chk("d4 pre_reset tx", 32'(tx0), 32'd0);
    start0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("d4 reset tx", 32'(tx0), 32'd1);
    chk("d4 reset busy", 32'(busy0), 32'd0);
    chk("d4 reset addr", 32'(addr0), 32'd0);
    chk("d4 reset done", 32'(done0), 32'd0);
    reset = 1'b0;
    rq0.delete();
    @(negedge clk);
    start0 = 1'b1;
    check_dump(0, "d5", 0);
    chk("d5 reads", 32'(rq0.size()), 32'd2);
    chk("d5 first addr", 32'(rq0[0]), 32'd0);
    start1 = 1'b1;
    check_dump(1, "big", 0);
    chk("big reads", 32'(rq1.size()), 32'd64);
    foreach (rq1[i]) chk($sformatf("big addr%0d", i), 32'(rq1[i]), 32'(i));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_uart_dump.md
# ram_uart_dump

Post-run result dumper sitting directly downstream of the CPU core. When the CPU raises its end-of-execution flag, this block takes over the data-RAM read port and walks every RAM word from address 0 upward. It serializes each 16-bit word onto a UART TX line as two 8N1 bytes, high byte first. It then reports completion and stays idle until re-armed.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per UART bit; must be ≥ 2.
- `ADDR_WIDTH`, 6: RAM address width.
- `DATA_WIDTH`, 16: RAM word width; fixed at 16 (two bytes per word).
- `WORD_COUNT`, 64: number of words dumped, addresses 0 .. WORD_COUNT-1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  level input, driven from the CPU end-of-execution flag.
- `ram_data`  in  16  RAM read data, valid the cycle after `ram_re`.
- `ram_addr`  out  ADDR_WIDTH  RAM read address.
- `ram_re`  out  1  RAM read strobe, one cycle per word.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high from dump start until the last stop bit ends; top level muxes the RAM address to `ram_addr` while high.
- `done`  out  1  high after a completed dump until `start` falls.

## Operation
- States: IDLE, FETCH, LATCH, SEND, DONE, plus CKSUM when configured.
- IDLE -> FETCH when `start`=1 and the re-arm flag is set. The re-arm flag is set by reset and by `start`=0 sampled in DONE.
- Word index resets to 0 on entry from IDLE.
- FETCH (1 cycle): `ram_re`=1, `ram_addr`=index.
- LATCH (1 cycle): capture `ram_data` into a 16-bit holding register and load the high byte into the TX shifter.
- SEND: transmit the frame as start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts exactly CLK_DIV cycles.
  - After the high-byte stop bit, the low byte frame starts on the next cycle with no gap.
  - After the low-byte stop bit, if index = WORD_COUNT-1, go to DONE (or CKSUM when configured). Otherwise increment index and go to FETCH.
- DONE: `busy`=0, `done`=1. When `start`=0, set the re-arm flag, clear `done`, and go to IDLE.
- Index arithmetic is ADDR_WIDTH bits. The terminal compare is against WORD_COUNT-1, so the index never wraps mid-dump. WORD_COUNT = 2^ADDR_WIDTH is legal.
- `ram_addr` holds the current index outside FETCH. It is 0 in IDLE.
- `start` is ignored outside IDLE and DONE. Deasserting it mid-dump does not abort the dump.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `ram_re`=0, `ram_addr`=0, state IDLE, re-arm flag set.
- Reset mid-dump forces these values on the next edge. The partial frame is abandoned, and `tx` returns high immediately.
- `busy` rises the cycle after `start` is sampled high in IDLE, i.e. on entry to FETCH.
- First start bit begins 2 cycles after FETCH entry.
- Per word: 2 + 20·CLK_DIV cycles.
- Full dump, from FETCH entry to DONE entry: WORD_COUNT·(2 + 20·CLK_DIV) cycles, plus 10·CLK_DIV when the checksum is enabled.
- Between words, `tx` stays high for the 2-cycle FETCH/LATCH gap.
- `done` and the `busy` fall are simultaneous, on the cycle after the final stop bit's last cycle.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - An 8-bit running XOR of every transmitted data byte is kept. It is cleared on leaving IDLE.
  - After the last word, state CKSUM sends that byte as one additional 8N1 frame before DONE.
- Not defined: no CKSUM state and no checksum register. The dump ends after the last word's low byte.

## Test plan
- CLK_DIV=4, WORD_COUNT=2, RAM[0]=16'hA55A, RAM[1]=16'h0102, pulse `start` high and hold it -> `tx` decodes bytes A5, 5A, 01, 02. `done` rises exactly 2·(2+80) cycles after FETCH entry.
- Hold `start` high after DONE -> no second dump, and `ram_re` stays 0. Drop `start` then raise it again -> an identical second dump.
- Assert `reset` during the second bit of byte 5A -> next cycle `tx`=1, `busy`=0, `ram_addr`=0. A subsequent `start` restarts from address 0.
- Default WORD_COUNT=64, RAM[i]=i -> addresses 0..63 are read in order with exactly one `ram_re` each. The final bytes are 00 3F, and there is no wrap to address 0.
- With `DUMP_CHECKSUM_EN` and the first scenario's data -> a fifth byte equal to A5^5A^01^02 = 8'hFC follows, and `done` is delayed by 40 cycles.
- Toggle `start` low mid-dump -> the dump completes unchanged.
